mem_port_arbiter: RTL

- Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage pipeline.
- Sequences each access with a request/ready handshake and returns data with a one-cycle valid pulse.
- Produces per-stage stall signals for the hazard logic.
- Prioritises data accesses over fetches, with a starvation limit that guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (read-only) and
// data access (read/write). Data wins ties, bounded by a starvation counter.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             cancel_flag;
    logic             if_elig;
    logic             dm_elig;
    logic             grant_if;
    logic             grant_dm;
    logic             done;
    logic             cancel_now;

    // A requester whose valid pulse is going out this cycle is still holding
    // its old request, so it must not be granted again.
    assign if_elig    = if_req & ~if_valid;
    assign dm_elig    = dm_req & ~dm_valid;
    assign cancel_now = cancel_flag | if_cancel;
    assign stall_f    = if_req & ~if_valid;
    assign stall_m    = dm_req & ~dm_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (dm_elig && (!if_elig || starve_cnt < CNT_W'(STARVE_LIMIT))) begin
                    grant_dm   = 1'b1;
                    state_next = DM_BUSY;
                end else if (if_elig) begin
                    grant_if   = 1'b1;
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts data grants won while a fetch was also waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if || !if_req) begin
                starve_cnt <= '0;
            end else if (grant_dm && if_elig) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cancel_flag <= 1'b0;
        end else if (done) begin
            cancel_flag <= 1'b0;
        end else if (state == IF_BUSY && if_cancel) begin
            cancel_flag <= 1'b1;
        end
    end

    // Memory-side request registers and returned-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end
            if (done) begin
                mem_req <= 1'b0;
                if (state == DM_BUSY) begin
                    dm_valid <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                end else if (!cancel_now) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
